// File: rtl/printf_tx_pkg.sv
// printf_tx_pkg: shared types and constants for the printf transmitter.
// Holds the FSM state enum, the end-of-test character and a small max helper.
// No ports; imported by printf_tx and printf_tx_fifo.
package printf_tx_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} tx_state_t;

  localparam logic [7:0] EOT_CHAR = 8'h04;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/printf_tx_fifo.sv
// printf_tx_fifo: in-order synchronous byte FIFO, DEPTH entries (power of 2).
// Latency: a pushed byte is visible at pop_data from the next cycle; count is registered.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst (sync active-high), push/push_data, pop/pop_data, full, empty, count.
module printf_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/printf_tx.sv
// printf_tx: byte-wide debug-print transmitter framing chars as SETUP/STROBE/GAP on the printf pins.
// Latency: push at edge N -> pop/tx_data at N+1, strobe rises N+1+SETUP_CYCLES; one char per 1+SETUP+STROBE+GAP cycles.
// Backpressure: in_ready = FIFO not full and not in reset (and, with PRINTF_TX_EOT_LOCK_EN, no EOT accepted yet).
// Ports: wb_clk_i, wb_rst_i (sync active-high), in_valid/in_data/in_ready, tx_data, tx_strobe, tx_oeb, busy, eot_sent.
// Optional macro PRINTF_TX_EOT_LOCK_EN: refuse all input after 0x04 has been accepted, until reset.
module printf_tx
  import printf_tx_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  output logic [8:0] tx_oeb,
  output logic       busy,
  output logic       eot_sent
);

  localparam int MAXC = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
  localparam int CW   = $clog2(MAXC + 1);

  tx_state_t             state;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;
  logic [7:0]            fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign tx_oeb = '0;
  assign push   = in_valid && in_ready;
  // Decision uses the registered count, so a byte pushed this edge waits one cycle.
  assign pop    = (state == IDLE) && (fifo_count != '0);
  assign busy   = !fifo_empty || (state != IDLE);

`ifdef PRINTF_TX_EOT_LOCK_EN
  logic eot_lock;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                          eot_lock <= 1'b0;
    else if (push && in_data == EOT_CHAR)  eot_lock <= 1'b1;
  end

  assign in_ready = !fifo_full && !wb_rst_i && !eot_lock;
`else
  assign in_ready = !fifo_full && !wb_rst_i;
`endif

  printf_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Each phase loads N-1 and leaves on the cycle the counter reads zero,
  // so a phase occupies exactly N cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_data   <= 8'h00;
      tx_strobe <= 1'b0;
      eot_sent  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= fifo_head;
            cnt     <= CW'(SETUP_CYCLES - 1);
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            tx_strobe <= 1'b1;
            cnt       <= CW'(STROBE_CYCLES - 1);
            state     <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            tx_strobe <= 1'b0;
            cnt       <= CW'(GAP_CYCLES - 1);
            state     <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (tx_data == EOT_CHAR) eot_sent <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_printf_tx.sv
// tb_printf_tx: self-checking bench for printf_tx with default parameters.
// Expected characters are queued on acceptance and compared at each strobe rising edge.
// Honours PRINTF_TX_EOT_LOCK_EN to select the expected EOT behaviour.
module tb_printf_tx;

  localparam int DEPTH = 8;
  localparam int SU    = 2;
  localparam int ST    = 4;
  localparam int GP    = 4;
  localparam int FRAME = 1 + SU + ST + GP;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic [8:0] tx_oeb;
  logic       busy;
  logic       eot_sent;

  int         checks     = 0;
  int         errors     = 0;
  int         strobe_cnt = 0;
  int         last_rise  = -1;
  bit         gap_chk    = 1'b0;
  bit         saw_nr     = 1'b0;
  logic [7:0] held       = 8'h00;
  logic [7:0] sb[$];

  printf_tx #(
    .DEPTH(DEPTH), .SETUP_CYCLES(SU), .STROBE_CYCLES(ST), .GAP_CYCLES(GP)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_strobe (tx_strobe),
    .tx_oeb    (tx_oeb),
    .busy      (busy),
    .eot_sent  (eot_sent)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Strobe monitor: pops the scoreboard on each rising edge, checks frame
  // spacing when enabled, and checks tx_data stays put while strobe is high.
  initial begin : mon
    int         mc;
    logic       prev;
    logic [7:0] exp_c;
    mc   = 0;
    prev = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #2;
      mc++;
      if (tx_strobe === 1'b1 && prev !== 1'b1) begin
        strobe_cnt++;
        held = tx_data;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got tx_data=%h, expected no strobe", tx_data);
        end else begin
          exp_c = sb.pop_front();
          if (tx_data !== exp_c) begin
            errors++;
            $display("FAIL strobe_data: got %h, expected %h", tx_data, exp_c);
          end
        end
        if (gap_chk && last_rise >= 0) begin
          checks++;
          if (mc - last_rise != FRAME) begin
            errors++;
            $display("FAIL strobe_spacing: got %0d cycles, expected %0d", mc - last_rise, FRAME);
          end
        end
        last_rise = mc;
      end else if (tx_strobe === 1'b1) begin
        checks++;
        if (tx_data !== held) begin
          errors++;
          $display("FAIL data_stable: got %h, expected %h", tx_data, held);
        end
      end
      prev = tx_strobe;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_reset();
    wb_rst_i = 1'b1;
    in_valid = 1'b0;
    step();
    wb_rst_i  = 1'b0;
    sb.delete();
    last_rise = -1;
    step();
  endtask

  // Presents c (leaving in_valid high) until it is accepted, then queues it.
  task automatic send(input logic [7:0] c);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && t < 200) begin
      saw_nr = 1'b1;
      step();
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 200 cycles", in_ready);
    end else begin
      @(posedge wb_clk_i);
      sb.push_back(c);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin
      step();
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, expected idle", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (in_ready  !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    checks++; if (tx_data   !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h, expected 00", tx_data); end
    checks++; if (tx_strobe !== 1'b0)  begin errors++; $display("FAIL rst_strobe: got %b, expected 0", tx_strobe); end
    checks++; if (busy      !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (eot_sent  !== 1'b0)  begin errors++; $display("FAIL rst_eot: got %b, expected 0", eot_sent); end
    checks++; if (tx_oeb    !== 9'h0)  begin errors++; $display("FAIL rst_oeb: got %h, expected 000", tx_oeb); end
    wb_rst_i = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
    step();
  endtask

  task automatic test_single();
    int   base;
    logic exp_s;
    logic exp_b;
    base     = strobe_cnt;
    in_valid = 1'b1;
    in_data  = 8'h41;
    step();
    sb.push_back(8'h41);
    in_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (tx_data !== 8'h41) begin errors++; $display("FAIL single_pop: got %h, expected 41", tx_data); end
      end
      exp_s = (k >= SU + 1) && (k <= SU + ST);
      exp_b = (k < FRAME);
      checks++;
      if (tx_strobe !== exp_s) begin errors++; $display("FAIL single_strobe k=%0d: got %b, expected %b", k, tx_strobe, exp_s); end
      checks++;
      if (busy !== exp_b) begin errors++; $display("FAIL single_busy k=%0d: got %b, expected %b", k, busy, exp_b); end
    end
    checks++;
    if (strobe_cnt - base != 1) begin errors++; $display("FAIL single_count: got %0d strobes, expected 1", strobe_cnt - base); end
  endtask

  task automatic test_burst();
    string s;
    int    base;
    s         = "Hello World!";
    base      = strobe_cnt;
    saw_nr    = 1'b0;
    gap_chk   = 1'b1;
    last_rise = -1;
    for (int i = 0; i < s.len(); i++) send(s[i]);
    in_valid = 1'b0;
    wait_idle();
    gap_chk = 1'b0;
    checks++;
    if (saw_nr !== 1'b1) begin errors++; $display("FAIL burst_full: in_ready drop seen=%b, expected 1", saw_nr); end
    checks++;
    if (strobe_cnt - base != 12) begin errors++; $display("FAIL burst_count: got %0d strobes, expected 12", strobe_cnt - base); end
  endtask

  task automatic test_eot();
    int  base;
    int  exp_n;
    bit  took;
    apply_reset();
    base = strobe_cnt;
    send(8'h4F);
    send(8'h4B);
    send(8'h04);
    in_valid = 1'b0;
    checks++;
    if (eot_sent !== 1'b0) begin errors++; $display("FAIL eot_early: got %b, expected 0", eot_sent); end
`ifdef PRINTF_TX_EOT_LOCK_EN
    exp_n = 3;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL eot_lock_ready: got %b, expected 0", in_ready); end
    took     = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h41;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) took = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (took !== 1'b0) begin errors++; $display("FAIL eot_lock_refuse: accepted=%b, expected 0", took); end
`else
    exp_n = 4;
    took  = 1'b0;
    send(8'h41);
    in_valid = 1'b0;
`endif
    wait_idle();
    checks++;
    if (strobe_cnt - base != exp_n) begin errors++; $display("FAIL eot_count: got %0d strobes, expected %0d", strobe_cnt - base, exp_n); end
    checks++;
    if (eot_sent !== 1'b1) begin errors++; $display("FAIL eot_sent: got %b, expected 1", eot_sent); end
  endtask

  task automatic test_reset_mid();
    int t;
    int base;
    apply_reset();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    in_valid = 1'b0;
    t = 0;
    while (tx_strobe !== 1'b1 && t < 50) begin step(); t++; end
    checks++;
    if (t >= 50) begin errors++; $display("FAIL midrst_wait: strobe=%b, expected 1 within 50 cycles", tx_strobe); end
    step();
    wb_rst_i = 1'b1;
    step();
    checks++; if (tx_strobe !== 1'b0)  begin errors++; $display("FAIL midrst_strobe: got %b, expected 0", tx_strobe); end
    checks++; if (tx_data   !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h, expected 00", tx_data); end
    checks++; if (busy      !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    wb_rst_i = 1'b0;
    sb.delete();
    last_rise = -1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, expected 1", in_ready); end
    base = strobe_cnt;
    repeat (60) step();
    checks++;
    if (strobe_cnt != base) begin errors++; $display("FAIL midrst_nostrobe: got %0d strobes, expected 0", strobe_cnt - base); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b, expected 0", busy); end
  endtask

  // Fills to DEPTH-1 then pushes exactly on every pop edge, so the count
  // must stay at DEPTH-1 while the pointers wrap twice over 2*DEPTH chars.
  task automatic test_wrap();
    int base;
    int off;
    int target;
    apply_reset();
    base      = strobe_cnt;
    gap_chk   = 1'b1;
    last_rise = -1;
    off       = -1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(i);
      step();
      off++;
      sb.push_back(in_data);
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      target = 1 + FRAME * (k + 1);
      while (off < target - 1) begin step(); off++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready k=%0d: got %b, expected 1", k, in_ready); end
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(DEPTH + k);
      step();
      off++;
      sb.push_back(in_data);
      in_valid = 1'b0;
      checks++;
      if (dut.u_fifo.count !== 4'(DEPTH - 1)) begin
        errors++;
        $display("FAIL wrap_count k=%0d: got %0d, expected %0d", k, dut.u_fifo.count, DEPTH - 1);
      end
    end
    wait_idle();
    gap_chk = 1'b0;
    checks++;
    if (strobe_cnt - base != 2 * DEPTH) begin errors++; $display("FAIL wrap_total: got %0d strobes, expected %0d", strobe_cnt - base, 2 * DEPTH); end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_burst();
    test_eot();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/printf_tx.md
# printf_tx

Byte-wide debug-print transmitter in the user project. It drives the simulation printf channel: an 8-bit character on `mprj_io[15:8]` plus a strobe that the bench samples on its rising edge. Firmware or user logic pushes characters through a valid/ready port. A small FIFO decouples producers from the slow, fixed-timing output framing. Character 0x04 is the end-of-test marker.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and at least 2.
- `SETUP_CYCLES`, 2: cycles `tx_data` is stable before `tx_strobe` rises. Must be at least 1.
- `STROBE_CYCLES`, 4: cycles `tx_strobe` stays high. Must be at least 1.
- `GAP_CYCLES`, 4: cycles `tx_data` is held after `tx_strobe` falls. Must be at least 1.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `in_valid` in 1: producer has a character.
- `in_data` in 8: character.
- `in_ready` out 1: FIFO can accept.
- `tx_data` out 8: drives `mprj_io[15:8]`.
- `tx_strobe` out 1: printf strobe.
- `tx_oeb` out 9: output enables for the data and strobe pins, active-low. Constant 0.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not in IDLE.
- `eot_sent` out 1: sticky. Set when 0x04 finishes its GAP phase.

## Operation
- A push occurs when `in_valid && in_ready`. `in_ready = !full && !wb_rst_i`, plus the EOT lock described under Configuration.
- The FIFO is strictly in order. There is no bypass: a character pushed into an empty FIFO is not popped in the same cycle.
- FSM states are IDLE, SETUP, STROBE and GAP. A down-counter of width `$clog2(max(SETUP,STROBE,GAP)+1)` times each phase.
- IDLE: if the FIFO count is non-zero before the edge, pop, register the head into `tx_data`, load SETUP_CYCLES, and go to SETUP.
- SETUP: when the counter expires, go to STROBE.
- STROBE: `tx_strobe` is high. When the counter expires, go to GAP.
- GAP: when the counter expires, go to IDLE. If the character just sent equals `EOT_CHAR`, set `eot_sent`.
- `tx_data` changes only when IDLE pops. It holds the last character indefinitely afterwards.
- Push and pop in the same cycle are both legal. The count is unchanged, and the pointers wrap modulo `DEPTH`.
- Reset values: `tx_data`=0, `tx_strobe`=0, `busy`=0, `eot_sent`=0, `in_ready`=0 during reset and 1 on the first cycle after it, FIFO empty, state IDLE.
- Reset mid-frame, including during STROBE, aborts the frame. `tx_strobe` is 0 after that edge and the FIFO contents are discarded.

## Timing
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - pop and `tx_data` update at edge N+1;
  - `tx_strobe` rises at edge N+1+SETUP_CYCLES and falls STROBE_CYCLES later;
  - the FSM returns to IDLE after GAP_CYCLES more.
- Sustained rate is one character per 1+SETUP+STROBE+GAP cycles. This is 11 with the defaults.
- `tx_strobe` is registered and glitch-free. Minimum low time between strobes is GAP_CYCLES+1+SETUP_CYCLES.
- `in_ready` is driven from the registered count, with no combinational path from `in_valid`.

## Configuration
- `PRINTF_TX_EOT_LOCK_EN` defined:
  - once 0x04 has been accepted, `in_ready` is forced to 0 until reset;
  - characters already queued ahead of the 0x04 still transmit;
  - `eot_sent` sets after the 0x04 GAP phase.
- Macro undefined: 0x04 is an ordinary character and no lock occurs. `eot_sent` still sets as an indicator, and later characters continue to transmit.

## Structure
- Package `printf_tx_pkg` holds:
  - the state enum `tx_state_t` {IDLE, SETUP, STROBE, GAP};
  - `EOT_CHAR = 8'h04`.
- Sub-module `printf_tx_fifo` is a synchronous FIFO: parameter `DEPTH`, width 8, with push/pop, full/empty and registered count. It uses the same clock and reset.
- Top level contains the FSM, the phase counter, the output registers and the EOT logic.

## Test plan
- Single character: push 0x41 at cycle 10 with defaults.
  - Required: `tx_data`=0x41 at cycle 11; `tx_strobe` high cycles 13–16; `busy` low from cycle 21.
- Burst: present 12 characters "Hello World!" back-to-back with DEPTH=8.
  - Required: `in_ready` drops when the FIFO is full; the output order matches exactly; strobe rising edges are 11 cycles apart; `tx_data` is stable from each rise until the next pop.
- EOT with `PRINTF_TX_EOT_LOCK_EN`: push 0x4F, 0x4B, 0x04, 0x41.
  - Required: 0x41 is refused because `in_ready` stays 0; three strobes occur; `eot_sent`=1 after the third GAP.
- EOT without the macro, same stimulus.
  - Required: four strobes, with 0x41 last; `eot_sent`=1.
- Reset mid-STROBE with 3 characters queued: assert `wb_rst_i` for 1 cycle.
  - Required: `tx_strobe`=0, `tx_data`=0, `busy`=0 the next cycle; no further strobes; `in_ready`=1.
- Simultaneous push and pop at count=DEPTH−1, including pointer wrap.
  - Required: count unchanged and no data lost across 2×DEPTH characters.
